// File: rtl/adma_as_atx_issue.sv
// Issue stage behind the channel arbiter: forwards AR/AW halves on independent AXI
// address channels and queues each transaction's channel id for the write-data path.
module adma_as_atx_issue #(
    parameter int DMA_CHN_NUM   = 4,
    parameter int SRC_ADDR_W    = 32,
    parameter int DST_ADDR_W    = 32,
    parameter int MST_ID_W      = 5,
    parameter int ATX_LEN_W     = 8,
    parameter int OST_MAX       = 8,
    parameter int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM),
    parameter int OST_CNT_W     = $clog2(OST_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
    input  logic [MST_ID_W-1:0]      atx_arid,
    input  logic [SRC_ADDR_W-1:0]    atx_araddr,
    input  logic [ATX_LEN_W-1:0]     atx_arlen,
    input  logic [1:0]               atx_arburst,
    input  logic [MST_ID_W-1:0]      atx_awid,
    input  logic [DST_ADDR_W-1:0]    atx_awaddr,
    input  logic [ATX_LEN_W-1:0]     atx_awlen,
    input  logic [1:0]               atx_awburst,
    input  logic                     atx_vld,
    output logic                     atx_rdy,
    output logic [MST_ID_W-1:0]      m_arid,
    output logic [SRC_ADDR_W-1:0]    m_araddr,
    output logic [ATX_LEN_W-1:0]     m_arlen,
    output logic [1:0]               m_arburst,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    output logic [MST_ID_W-1:0]      m_awid,
    output logic [DST_ADDR_W-1:0]    m_awaddr,
    output logic [ATX_LEN_W-1:0]     m_awlen,
    output logic [1:0]               m_awburst,
    output logic                     m_awvalid,
    input  logic                     m_awready,
    output logic [DMA_CHN_NUM_W-1:0] wchn_id,
    output logic                     wchn_vld,
    input  logic                     wchn_rdy,
    output logic [OST_CNT_W-1:0]     ost_cnt
);

    localparam int PTR_W = $clog2(OST_MAX);
    localparam logic [OST_CNT_W-1:0] CNT_FULL = OST_CNT_W'(OST_MAX);

    logic                     ar_free;
    logic                     aw_free;
    logic                     accept;
    logic                     pop;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [DMA_CHN_NUM_W-1:0] fifo_mem [OST_MAX];

    assign ar_free = !m_arvalid || m_arready;
    assign aw_free = !m_awvalid || m_awready;
    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign atx_rdy = ar_free && aw_free && (ost_cnt != CNT_FULL);
    assign accept  = atx_vld && atx_rdy;
    assign wchn_vld = (ost_cnt != '0);
    assign pop      = wchn_vld && wchn_rdy;
    assign wchn_id  = wchn_vld ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_arvalid <= 1'b0;
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arburst <= '0;
        end else if (accept) begin
            m_arvalid <= 1'b1;
            m_arid    <= atx_arid;
            m_araddr  <= atx_araddr;
            m_arlen   <= atx_arlen;
            m_arburst <= atx_arburst;
        end else if (m_arready) begin
            m_arvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_awvalid <= 1'b0;
            m_awid    <= '0;
            m_awaddr  <= '0;
            m_awlen   <= '0;
            m_awburst <= '0;
        end else if (accept) begin
            m_awvalid <= 1'b1;
            m_awid    <= atx_awid;
            m_awaddr  <= atx_awaddr;
            m_awlen   <= atx_awlen;
            m_awburst <= atx_awburst;
        end else if (m_awready) begin
            m_awvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= atx_chn_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ost_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept, pop})
                2'b10:   ost_cnt <= ost_cnt + OST_CNT_W'(1);
                2'b01:   ost_cnt <= ost_cnt - OST_CNT_W'(1);
                default: ost_cnt <= ost_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_adma_as_atx_issue.sv
// Directed bench for adma_as_atx_issue: issue latency, AW backpressure, outstanding
// limit, full FIFO with simultaneous pop, streaming order across wrap, async reset.
module tb_adma_as_atx_issue;

    logic        clk;
    logic        rst_n;
    logic [1:0]  atx_chn_id;
    logic [4:0]  atx_arid;
    logic [31:0] atx_araddr;
    logic [7:0]  atx_arlen;
    logic [1:0]  atx_arburst;
    logic [4:0]  atx_awid;
    logic [31:0] atx_awaddr;
    logic [7:0]  atx_awlen;
    logic [1:0]  atx_awburst;
    logic        atx_vld;
    logic        atx_rdy;
    logic [4:0]  m_arid;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [4:0]  m_awid;
    logic [31:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [1:0]  m_awburst;
    logic        m_awvalid;
    logic        m_awready;
    logic [1:0]  wchn_id;
    logic        wchn_vld;
    logic        wchn_rdy;
    logic [3:0]  ost_cnt;

    int n_cmp = 0;
    int n_err = 0;

    adma_as_atx_issue dut (
        .clk(clk), .rst_n(rst_n),
        .atx_chn_id(atx_chn_id),
        .atx_arid(atx_arid), .atx_araddr(atx_araddr), .atx_arlen(atx_arlen), .atx_arburst(atx_arburst),
        .atx_awid(atx_awid), .atx_awaddr(atx_awaddr), .atx_awlen(atx_awlen), .atx_awburst(atx_awburst),
        .atx_vld(atx_vld), .atx_rdy(atx_rdy),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arburst(m_arburst),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .wchn_id(wchn_id), .wchn_vld(wchn_vld), .wchn_rdy(wchn_rdy), .ost_cnt(ost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_atx(input logic [1:0] chn, input logic [31:0] ara, input logic [31:0] awa,
                             input logic [7:0] len);
        atx_chn_id  = chn;
        atx_arid    = 5'd1;
        atx_araddr  = ara;
        atx_arlen   = len;
        atx_arburst = 2'b01;
        atx_awid    = 5'd3;
        atx_awaddr  = awa;
        atx_awlen   = len;
        atx_awburst = 2'b01;
        atx_vld     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        atx_vld = 1'b0;
        drive_atx(2'd0, 32'h0, 32'h0, 8'h0);
        atx_vld = 1'b0;
        m_arready = 1'b1;
        m_awready = 1'b1;
        wchn_rdy = 1'b0;
        cycle();
        cycle();
        n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid got %0b want 0", m_arvalid); end
        n_cmp++; if (m_awvalid !== 1'b0) begin n_err++; $display("FAIL rst_awvalid got %0b want 0", m_awvalid); end
        n_cmp++; if (m_araddr !== 32'h0) begin n_err++; $display("FAIL rst_araddr got %0h want 0", m_araddr); end
        n_cmp++; if (m_awaddr !== 32'h0) begin n_err++; $display("FAIL rst_awaddr got %0h want 0", m_awaddr); end
        n_cmp++; if (wchn_vld !== 1'b0) begin n_err++; $display("FAIL rst_wchn_vld got %0b want 0", wchn_vld); end
        n_cmp++; if (wchn_id !== 2'd0) begin n_err++; $display("FAIL rst_wchn_id got %0d want 0", wchn_id); end
        n_cmp++; if (ost_cnt !== 4'd0) begin n_err++; $display("FAIL rst_ost_cnt got %0d want 0", ost_cnt); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_single();
        drive_atx(2'd2, 32'h1000, 32'h8000, 8'd15);
        n_cmp++; if (atx_rdy !== 1'b1) begin n_err++; $display("FAIL t1_atx_rdy got %0b want 1", atx_rdy); end
        cycle();
        atx_vld = 1'b0;
        n_cmp++; if (m_arvalid !== 1'b1) begin n_err++; $display("FAIL t1_arvalid got %0b want 1", m_arvalid); end
        n_cmp++; if (m_awvalid !== 1'b1) begin n_err++; $display("FAIL t1_awvalid got %0b want 1", m_awvalid); end
        n_cmp++; if (m_araddr !== 32'h1000) begin n_err++; $display("FAIL t1_araddr got %0h want 1000", m_araddr); end
        n_cmp++; if (m_awaddr !== 32'h8000) begin n_err++; $display("FAIL t1_awaddr got %0h want 8000", m_awaddr); end
        n_cmp++; if (m_arlen !== 8'd15) begin n_err++; $display("FAIL t1_arlen got %0d want 15", m_arlen); end
        n_cmp++; if (m_awlen !== 8'd15) begin n_err++; $display("FAIL t1_awlen got %0d want 15", m_awlen); end
        n_cmp++; if (m_arid !== 5'd1) begin n_err++; $display("FAIL t1_arid got %0d want 1", m_arid); end
        n_cmp++; if (m_awid !== 5'd3) begin n_err++; $display("FAIL t1_awid got %0d want 3", m_awid); end
        n_cmp++; if (m_awburst !== 2'b01) begin n_err++; $display("FAIL t1_awburst got %0b want 01", m_awburst); end
        n_cmp++; if (wchn_vld !== 1'b1) begin n_err++; $display("FAIL t1_wchn_vld got %0b want 1", wchn_vld); end
        n_cmp++; if (wchn_id !== 2'd2) begin n_err++; $display("FAIL t1_wchn_id got %0d want 2", wchn_id); end
        n_cmp++; if (ost_cnt !== 4'd1) begin n_err++; $display("FAIL t1_ost_cnt got %0d want 1", ost_cnt); end
        cycle();
        n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL t1_arvalid_drop got %0b want 0", m_arvalid); end
        n_cmp++; if (m_awvalid !== 1'b0) begin n_err++; $display("FAIL t1_awvalid_drop got %0b want 0", m_awvalid); end
        wchn_rdy = 1'b1;
        cycle();
        wchn_rdy = 1'b0;
        n_cmp++; if (ost_cnt !== 4'd0) begin n_err++; $display("FAIL t1_pop_ost got %0d want 0", ost_cnt); end
        n_cmp++; if (wchn_vld !== 1'b0) begin n_err++; $display("FAIL t1_pop_vld got %0b want 0", wchn_vld); end
    endtask

    task automatic test_aw_backpressure();
        m_arready = 1'b1;
        m_awready = 1'b0;
        drive_atx(2'd1, 32'h2000, 32'h9000, 8'd3);
        cycle();
        drive_atx(2'd3, 32'h3000, 32'hA000, 8'd7);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (m_arvalid !== (i == 0)) begin n_err++; $display("FAIL t2_arvalid[%0d] got %0b want %0b", i, m_arvalid, (i == 0)); end
            n_cmp++; if (m_awvalid !== 1'b1) begin n_err++; $display("FAIL t2_awvalid[%0d] got %0b want 1", i, m_awvalid); end
            n_cmp++; if (m_awaddr !== 32'h9000) begin n_err++; $display("FAIL t2_awaddr[%0d] got %0h want 9000", i, m_awaddr); end
            n_cmp++; if (m_awlen !== 8'd3) begin n_err++; $display("FAIL t2_awlen[%0d] got %0d want 3", i, m_awlen); end
            n_cmp++; if (atx_rdy !== 1'b0) begin n_err++; $display("FAIL t2_atx_rdy[%0d] got %0b want 0", i, atx_rdy); end
            cycle();
        end
        m_awready = 1'b1;
        #1;
        n_cmp++; if (atx_rdy !== 1'b1) begin n_err++; $display("FAIL t2_atx_rdy_release got %0b want 1", atx_rdy); end
        cycle();
        atx_vld = 1'b0;
        n_cmp++; if (m_awaddr !== 32'hA000) begin n_err++; $display("FAIL t2_awaddr_next got %0h want a000", m_awaddr); end
        n_cmp++; if (m_araddr !== 32'h3000) begin n_err++; $display("FAIL t2_araddr_next got %0h want 3000", m_araddr); end
        n_cmp++; if (ost_cnt !== 4'd2) begin n_err++; $display("FAIL t2_ost_cnt got %0d want 2", ost_cnt); end
        n_cmp++; if (wchn_id !== 2'd1) begin n_err++; $display("FAIL t2_head0 got %0d want 1", wchn_id); end
        wchn_rdy = 1'b1;
        cycle();
        n_cmp++; if (wchn_id !== 2'd3) begin n_err++; $display("FAIL t2_head1 got %0d want 3", wchn_id); end
        n_cmp++; if (ost_cnt !== 4'd1) begin n_err++; $display("FAIL t2_ost_pop1 got %0d want 1", ost_cnt); end
        cycle();
        wchn_rdy = 1'b0;
        n_cmp++; if (ost_cnt !== 4'd0) begin n_err++; $display("FAIL t2_ost_pop2 got %0d want 0", ost_cnt); end
    endtask

    task automatic test_ost_limit();
        m_arready = 1'b1;
        m_awready = 1'b1;
        wchn_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_atx(2'(i), 32'h4000 + 32'(i), 32'hB000 + 32'(i), 8'd0);
            n_cmp++; if (atx_rdy !== 1'b1) begin n_err++; $display("FAIL t3_rdy_fill[%0d] got %0b want 1", i, atx_rdy); end
            cycle();
        end
        drive_atx(2'd2, 32'h4100, 32'hB100, 8'd0);
        n_cmp++; if (ost_cnt !== 4'd8) begin n_err++; $display("FAIL t3_ost_full got %0d want 8", ost_cnt); end
        n_cmp++; if (atx_rdy !== 1'b0) begin n_err++; $display("FAIL t3_rdy_9th got %0b want 0", atx_rdy); end
        cycle();
        n_cmp++; if (ost_cnt !== 4'd8) begin n_err++; $display("FAIL t3_ost_hold got %0d want 8", ost_cnt); end
        n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL t3_no_issue got %0b want 0", m_arvalid); end
    endtask

    // Entered with FIFO full and a push still offered (chn 2).
    task automatic test_full_push_pop();
        logic [1:0] order [8];
        order = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        wchn_rdy = 1'b1;
        n_cmp++; if (wchn_id !== 2'd0) begin n_err++; $display("FAIL t6_head got %0d want 0", wchn_id); end
        n_cmp++; if (atx_rdy !== 1'b0) begin n_err++; $display("FAIL t6_rdy_full got %0b want 0", atx_rdy); end
        cycle();
        wchn_rdy = 1'b0;
        n_cmp++; if (ost_cnt !== 4'd7) begin n_err++; $display("FAIL t6_ost got %0d want 7", ost_cnt); end
        n_cmp++; if (atx_rdy !== 1'b1) begin n_err++; $display("FAIL t6_rdy_resume got %0b want 1", atx_rdy); end
        cycle();
        atx_vld = 1'b0;
        n_cmp++; if (ost_cnt !== 4'd8) begin n_err++; $display("FAIL t6_ost_refill got %0d want 8", ost_cnt); end
        n_cmp++; if (m_araddr !== 32'h4100) begin n_err++; $display("FAIL t6_araddr got %0h want 4100", m_araddr); end
        wchn_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (wchn_id !== order[i]) begin n_err++; $display("FAIL t6_order[%0d] got %0d want %0d", i, wchn_id, order[i]); end
            cycle();
        end
        wchn_rdy = 1'b0;
        n_cmp++; if (ost_cnt !== 4'd0) begin n_err++; $display("FAIL t6_drain got %0d want 0", ost_cnt); end
    endtask

    task automatic test_back_to_back();
        m_arready = 1'b1;
        m_awready = 1'b1;
        wchn_rdy = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) begin
                n_cmp++; if (wchn_id !== 2'(k - 1)) begin n_err++; $display("FAIL t4_head[%0d] got %0d want %0d", k, wchn_id, 2'(k - 1)); end
                n_cmp++; if (ost_cnt !== 4'd1) begin n_err++; $display("FAIL t4_ost[%0d] got %0d want 1", k, ost_cnt); end
                n_cmp++; if (m_arvalid !== 1'b1) begin n_err++; $display("FAIL t4_arvalid[%0d] got %0b want 1", k, m_arvalid); end
                n_cmp++; if (m_araddr !== 32'h100 * 32'(k - 1)) begin n_err++; $display("FAIL t4_araddr[%0d] got %0h want %0h", k, m_araddr, 32'h100 * 32'(k - 1)); end
            end
            if (k < 20) begin
                drive_atx(2'(k), 32'h100 * 32'(k), 32'h7000 + 32'(k), 8'(k));
                n_cmp++; if (atx_rdy !== 1'b1) begin n_err++; $display("FAIL t4_rdy[%0d] got %0b want 1", k, atx_rdy); end
            end else begin
                atx_vld = 1'b0;
            end
            cycle();
        end
        wchn_rdy = 1'b0;
        n_cmp++; if (ost_cnt !== 4'd0) begin n_err++; $display("FAIL t4_ost_end got %0d want 0", ost_cnt); end
        n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL t4_arvalid_end got %0b want 0", m_arvalid); end
    endtask

    task automatic test_async_reset();
        m_arready = 1'b0;
        m_awready = 1'b0;
        wchn_rdy = 1'b0;
        drive_atx(2'd3, 32'h5000, 32'h6000, 8'd4);
        cycle();
        atx_vld = 1'b0;
        n_cmp++; if (m_arvalid !== 1'b1) begin n_err++; $display("FAIL t5_pre_arvalid got %0b want 1", m_arvalid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL t5_arvalid got %0b want 0", m_arvalid); end
        n_cmp++; if (m_awvalid !== 1'b0) begin n_err++; $display("FAIL t5_awvalid got %0b want 0", m_awvalid); end
        n_cmp++; if (m_araddr !== 32'h0) begin n_err++; $display("FAIL t5_araddr got %0h want 0", m_araddr); end
        n_cmp++; if (m_awaddr !== 32'h0) begin n_err++; $display("FAIL t5_awaddr got %0h want 0", m_awaddr); end
        n_cmp++; if (m_awlen !== 8'h0) begin n_err++; $display("FAIL t5_awlen got %0h want 0", m_awlen); end
        n_cmp++; if (ost_cnt !== 4'd0) begin n_err++; $display("FAIL t5_ost got %0d want 0", ost_cnt); end
        n_cmp++; if (wchn_vld !== 1'b0) begin n_err++; $display("FAIL t5_wchn_vld got %0b want 0", wchn_vld); end
        cycle();
        rst_n = 1'b1;
        m_arready = 1'b1;
        m_awready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL t5_stale_ar[%0d] got %0b want 0", i, m_arvalid); end
            n_cmp++; if (m_awvalid !== 1'b0) begin n_err++; $display("FAIL t5_stale_aw[%0d] got %0b want 0", i, m_awvalid); end
            n_cmp++; if (ost_cnt !== 4'd0) begin n_err++; $display("FAIL t5_stale_ost[%0d] got %0d want 0", i, ost_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_aw_backpressure();
        test_ost_limit();
        test_full_push_pop();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
